event_detector_sync: RTL and testbench
======================================

# event_detector_sync

Single-bit event detector for an asynchronous input. `i_Data` passes through a multi-flop synchronizer into the `clk` domain. Transitions of the synchronized level then become one-cycle, registered event pulses. It sits at the boundary between unsynchronized external or other-domain status lines and synchronous control logic that needs edge notifications.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops, legal range 2–4.
- `EDGE_SEL`, default 2'd2: edges that raise `o_Event`.
  - 0 = rising only.
  - 1 = falling only.
  - 2 = both.
  - 3 = reserved, behaves as both.
- `clk`, input, 1 bit: single clock; all flops use its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset; deassertion is synchronous to `clk` at system level.
- `i_Data`, input, 1 bit: asynchronous data line to monitor.
- `o_Event`, output, 1 bit: one-cycle pulse on a selected edge of the synchronized input.
- `o_Rise`, output, 1 bit: one-cycle pulse on a rising edge, independent of `EDGE_SEL`.
- `o_Fall`, output, 1 bit: one-cycle pulse on a falling edge, independent of `EDGE_SEL`.
- `o_Level`, output, 1 bit: synchronized level, i.e. the last synchronizer stage.

## Operation
- Synchronizer: `SYNC_STAGES` flops in series. `sync[0]` samples `i_Data`; `sync[k]` samples `sync[k-1]`.
- History flop `prev` samples `sync[last]` each cycle.
- Combinational detection:
  - rise = `sync[last]` & ~`prev`
  - fall = ~`sync[last]` & `prev`
  - evt = rise, fall, or rise|fall, per `EDGE_SEL`.
- Outputs:
  - `o_Rise`, `o_Fall` and `o_Event` are registered copies of rise, fall and evt, so they are glitch-free.
  - `o_Level` = `sync[last]`, unregistered beyond the synchronizer.
- Reset, asynchronous: all synchronizer flops, `prev`, and all outputs go to 0 immediately and hold while `reset` = 1.
- Post-reset behaviour:
  - History starts at 0, so an input already high at reset release produces exactly one rising event.
  - An input low at release produces no event.
- Pulse behaviour:
  - Each synchronized transition yields exactly one pulse of exactly one cycle.
  - Transitions on consecutive synchronized cycles yield back-to-back pulses.
- Input pulses shorter than one `clk` period may be missed; no capture is guaranteed.
- Reset asserted mid-pulse clears the outputs at once; the interrupted edge is not reported later.

## Timing
- `i_Data` stable before edge N, changed from its previous value:
  - `sync[0]` updates at edge N.
  - `sync[last]` updates at edge N+SYNC_STAGES-1.
  - `o_Event` is high from edge N+SYNC_STAGES to edge N+SYNC_STAGES+1.
- Latency is SYNC_STAGES+1 edges; 3 for the default.
- `o_Level` follows `i_Data` with SYNC_STAGES edges of latency.
- `o_Rise` and `o_Fall` are never high in the same cycle.
- `o_Event` = (`o_Rise`&sel_r) | (`o_Fall`&sel_f) in every cycle.
- No handshake; the consumer must sample every cycle.

## Structure
- Shared package `event_detector_pkg`:
  - Edge-select constants: `EDGE_RISE`=0, `EDGE_FALL`=1, `EDGE_BOTH`=2.
  - Default stage count constant.
- Sub-module `bit_synchronizer`:
  - Parameterized flop chain, `SYNC_STAGES` deep, with asynchronous active-high reset to 0.
  - Reusable elsewhere; the top level adds the history flop, detection and output registers.
- Add parameter checks with elaboration-time assertions: `SYNC_STAGES` ≥ 2 and ≤ 4.

## Test plan
- Reset: assert `reset` at 1 ns with `i_Data`=0, release at 6 ns. Required: all outputs 0 during reset and stay 0 while `i_Data` stays 0.
- Stream with a 10 ns clock: drive `i_Data`=0,1,1,1,0,0,0,1 on successive edges E1..E8, default parameters, with `i_Data` changing just after each edge. The 0→1 driven after E2 is sampled at E3 and the 1→0 driven after E5 is sampled at E6. Required:
  - `o_Event`/`o_Rise` pulse for one cycle after E5.
  - `o_Event`/`o_Fall` pulse for one cycle after E8.
  - A further rise pulse three edges after the final 1 is sampled.
  - No other pulses.
- `EDGE_SEL`=0 and =1 with the same stream. Required: `o_Event` shows only rise pulses or only fall pulses respectively; `o_Rise` and `o_Fall` are unchanged.
- `i_Data`=1 held through reset release. Required: exactly one `o_Rise`/`o_Event` pulse, 3 edges after the first post-reset edge.
- Toggle `i_Data` every cycle. Required: `o_Event` high every cycle once the pipeline fills, with alternating `o_Rise` and `o_Fall`.
- Assert `reset` asynchronously while `o_Event`=1. Required: `o_Event` drops before the next clock edge; no pulse follows release.

Source files
------------

// File: rtl/event_detector_pkg.sv
// Shared constants for the event detector: edge-select encodings and the
// default synchronizer depth.
package event_detector_pkg;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;

    localparam int DEFAULT_SYNC_STAGES = 2;

    // Encoding 3 is reserved and treated as both edges.
    function automatic logic sel_rise(input logic [1:0] edge_sel);
        return edge_sel != EDGE_FALL;
    endfunction

    function automatic logic sel_fall(input logic [1:0] edge_sel);
        return edge_sel != EDGE_RISE;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop single-bit synchronizer with asynchronous active-high reset to 0.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("bit_synchronizer: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/event_detector_sync.sv
// Synchronizes an asynchronous bit into clk and turns its transitions into
// registered one-cycle rise/fall/event pulses.
module event_detector_sync
    import event_detector_pkg::*;
#(
    parameter int         SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic [1:0] EDGE_SEL    = EDGE_BOTH
) (
    input  logic clk,
    input  logic reset,
    input  logic i_Data,
    output logic o_Event,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Level
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("event_detector_sync: SYNC_STAGES must be in 2..4");
    end

    localparam logic SEL_R = sel_rise(EDGE_SEL);
    localparam logic SEL_F = sel_fall(EDGE_SEL);

    logic level_p0;
    logic prev_p1;
    logic rise;
    logic fall;
    logic evt;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_Data),
        .q     (level_p0)
    );

    always_comb begin
        rise = level_p0 & ~prev_p1;
        fall = ~level_p0 & prev_p1;
        evt  = (rise & SEL_R) | (fall & SEL_F);
    end

    // History starts at 0 so an input already high at release reports one rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_p1 <= 1'b0;
            o_Rise  <= 1'b0;
            o_Fall  <= 1'b0;
            o_Event <= 1'b0;
        end else begin
            prev_p1 <= level_p0;
            o_Rise  <= rise;
            o_Fall  <= fall;
            o_Event <= evt;
        end
    end

    assign o_Level = level_p0;

endmodule

// File: tb/tb_event_detector_sync.sv
// Directed bench: three detectors (both/rise/fall edge select) share one
// input stream; outputs are sampled on the falling clock edge.
module tb_event_detector_sync;

    logic clk;
    logic reset;
    logic data;

    logic b_event, b_rise, b_fall, b_level;
    logic r_event, r_rise, r_fall, r_level;
    logic f_event, f_rise, f_fall, f_level;

    int vectors;
    int miscompares;

    event_detector_sync #(.SYNC_STAGES(2), .EDGE_SEL(2'd2)) dut_both (
        .clk(clk), .reset(reset), .i_Data(data),
        .o_Event(b_event), .o_Rise(b_rise), .o_Fall(b_fall), .o_Level(b_level)
    );

    event_detector_sync #(.SYNC_STAGES(2), .EDGE_SEL(2'd0)) dut_rise (
        .clk(clk), .reset(reset), .i_Data(data),
        .o_Event(r_event), .o_Rise(r_rise), .o_Fall(r_fall), .o_Level(r_level)
    );

    event_detector_sync #(.SYNC_STAGES(2), .EDGE_SEL(2'd1)) dut_fall (
        .clk(clk), .reset(reset), .i_Data(data),
        .o_Event(f_event), .o_Rise(f_rise), .o_Fall(f_fall), .o_Level(f_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_cycle(input string ph, input int k, input logic er, input logic ef);
        check($sformatf("%s%0d both.rise", ph, k), b_rise, er);
        check($sformatf("%s%0d both.fall", ph, k), b_fall, ef);
        check($sformatf("%s%0d both.event", ph, k), b_event, er | ef);
        check($sformatf("%s%0d rsel.event", ph, k), r_event, er);
        check($sformatf("%s%0d rsel.rise", ph, k), r_rise, er);
        check($sformatf("%s%0d rsel.fall", ph, k), r_fall, ef);
        check($sformatf("%s%0d fsel.event", ph, k), f_event, ef);
        check($sformatf("%s%0d fsel.rise", ph, k), f_rise, er);
        check($sformatf("%s%0d fsel.fall", ph, k), f_fall, ef);
    endtask

    task automatic check_levels(input string ph, input int k, input logic el);
        check($sformatf("%s%0d both.level", ph, k), b_level, el);
        check($sformatf("%s%0d rsel.level", ph, k), r_level, el);
        check($sformatf("%s%0d fsel.level", ph, k), f_level, el);
    endtask

    logic stream [1:12];
    logic lvl_exp [1:12];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        data        = 1'b0;
        stream  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1};
        lvl_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b1};

        // Reset asserted at 1 ns, released at 6 ns, input low.
        #1 reset = 1'b1;
        #2;
        check_cycle("rst", 0, 1'b0, 1'b0);
        check_levels("rst", 0, 1'b0);
        #3 reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_cycle("idle", k, 1'b0, 1'b0);
            check_levels("idle", k, 1'b0);
        end

        // Stream 0,1,1,1,0,0,0,1 then hold 1; checked after each edge Ek.
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1 data = stream[k];
            @(negedge clk);
            check_cycle("str", k, (k == 5) || (k == 11), (k == 8));
            check_levels("str", k, lvl_exp[k]);
        end

        // Input held high through reset release: one rise after the third edge.
        @(posedge clk);
        #1 reset = 1'b1;
        data = 1'b1;
        #2;
        check_cycle("hrst", 0, 1'b0, 1'b0);
        check_levels("hrst", 0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle("hold", k, (k == 3), 1'b0);
        end

        // Toggle every cycle: pulses every cycle once the pipeline fills.
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1 data = ~data;
            @(negedge clk);
            check_cycle("tog", k, (k >= 5) && (k % 2 == 1), (k >= 4) && (k % 2 == 0));
        end

        // Reset mid-pulse: outputs drop before the next edge, nothing follows.
        #1 reset = 1'b1;
        data = 1'b0;
        #1;
        check_cycle("arst", 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_cycle("post", k, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
